// File: rtl/lab3_seg_capture_encoder.sv
// Receive-side seven-segment capture: debounces each multiplexed digit, decodes the
// segment pattern back to a hex nibble and publishes a 16-bit word once all four digits arrive.
module lab3_seg_capture_encoder #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_i,
    input  logic [3:0]  an_i,
    input  logic        clear_i,
    output logic [15:0] value_o,
    output logic        valid_o,
    output logic        err_o,
    output logic [3:0]  mask_o
);

    localparam logic [CNT_W-1:0] STABLE    = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(STABLE_CNT - 1);

    logic [6:0]       s_seg, prev_seg;
    logic [3:0]       s_an, prev_an;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       staged [4];

    logic       legal;
    logic [3:0] nibble;
    logic [1:0] idx;
    logic       one_hot, good, same, commit, complete;

    always_comb begin
        legal  = 1'b1;
        nibble = 4'h0;
        case (s_seg)
            7'h7E: nibble = 4'h0;
            7'h30: nibble = 4'h1;
            7'h6D: nibble = 4'h2;
            7'h79: nibble = 4'h3;
            7'h33: nibble = 4'h4;
            7'h5B: nibble = 4'h5;
            7'h5F: nibble = 4'h6;
            7'h70: nibble = 4'h7;
            7'h7F: nibble = 4'h8;
            7'h7B: nibble = 4'h9;
            7'h77: nibble = 4'hA;
            7'h1F: nibble = 4'hB;
            7'h4E: nibble = 4'hC;
            7'h3D: nibble = 4'hD;
            7'h4F: nibble = 4'hE;
            7'h47: nibble = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        idx = 2'd0;
        case (s_an)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    // A digit commits exactly once per dwell: on the step from STABLE-1 to STABLE.
    assign one_hot  = (s_an != 4'h0) && ((s_an & (s_an - 4'h1)) == 4'h0);
    assign good     = one_hot && legal;
    assign same     = (s_seg == prev_seg) && (s_an == prev_an);
    assign commit   = !clear_i && good && same && (cnt == STABLE_M1);
    assign complete = !clear_i && (mask_o == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg    <= 7'h00;
            s_an     <= 4'h0;
            prev_seg <= 7'h00;
            prev_an  <= 4'h0;
            cnt      <= '0;
            value_o  <= 16'h0000;
            valid_o  <= 1'b0;
            err_o    <= 1'b0;
            mask_o   <= 4'h0;
            for (int i = 0; i < 4; i++) staged[i] <= 4'h0;
        end else begin
            s_seg    <= seg_i;
            s_an     <= an_i;
            prev_seg <= s_seg;
            prev_an  <= s_an;
            err_o    <= one_hot && !legal;
            valid_o  <= complete;

            if (complete)
                value_o <= {staged[3], staged[2], staged[1], staged[0]};
            if (commit)
                staged[idx] <= nibble;

            if (clear_i || !good)
                cnt <= '0;
            else if (!same)
                cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            else if (cnt != STABLE)
                cnt <= cnt + 1'b1;

            // A commit landing on the completion edge seeds the next frame.
            if (clear_i)
                mask_o <= 4'h0;
            else
                mask_o <= (complete ? 4'h0 : mask_o) | (commit ? s_an : 4'h0);
        end
    end

endmodule

// File: tb/tb_lab3_seg_capture_encoder.sv
// Self-checking bench for lab3_seg_capture_encoder: directed frames plus randomized
// digit streams compared every cycle against a behavioural model of the capture rules.
module tb_lab3_seg_capture_encoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_i;
    logic [3:0]  an_i;
    logic        clear_i;
    logic [15:0] value_o;
    logic        valid_o;
    logic        err_o;
    logic [3:0]  mask_o;

    int testsRun = 0;
    int testsFailed = 0;

    logic [6:0] segTab [16];

    int mSeg, mAn, mPrevSeg, mPrevAn, mRun;
    int mStaged [4];
    int mMask, mValue, mValid, mErr;

    lab3_seg_capture_encoder #(.STABLE_CNT(S), .CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg_i   (seg_i),
        .an_i    (an_i),
        .clear_i (clear_i),
        .value_o (value_o),
        .valid_o (valid_o),
        .err_o   (err_o),
        .mask_o  (mask_o)
    );

    always #5 clk = ~clk;

    function automatic int decode(int seg);
        for (int k = 0; k < 16; k++)
            if (int'(segTab[k]) == seg) return k;
        return -1;
    endfunction

    function automatic int popCount(int an);
        int c = 0;
        for (int k = 0; k < 4; k++) c += (an >> k) & 1;
        return c;
    endfunction

    function automatic int digitIndex(int an);
        for (int k = 0; k < 4; k++)
            if (an == (1 << k)) return k;
        return 0;
    endfunction

    task automatic resetModel();
        mSeg = 0; mAn = 0; mPrevSeg = 0; mPrevAn = 0; mRun = 0;
        for (int k = 0; k < 4; k++) mStaged[k] = 0;
        mMask = 0; mValue = 0; mValid = 0; mErr = 0;
    endtask

    // Advance the model by one clock edge using the inputs that were present at that edge.
    task automatic modelEdge();
        bit oneHot, good, bad, same, commit, complete;
        int newRun;
        oneHot   = (popCount(mAn) == 1);
        good     = oneHot && (decode(mSeg) >= 0);
        bad      = oneHot && (decode(mSeg) < 0);
        same     = (mSeg == mPrevSeg) && (mAn == mPrevAn);
        newRun   = 0;
        if (!clear_i && good)
            newRun = same ? ((mRun + 1 > S) ? S : mRun + 1) : 1;
        commit   = !clear_i && (newRun == S) && (mRun != S);
        complete = !clear_i && (mMask == 15);
        mValid   = complete;
        if (complete)
            mValue = (mStaged[3] << 12) | (mStaged[2] << 8) | (mStaged[1] << 4) | mStaged[0];
        mErr     = bad;
        if (clear_i) mMask = 0;
        else         mMask = (complete ? 0 : mMask) | (commit ? mAn : 0);
        if (commit) mStaged[digitIndex(mAn)] = decode(mSeg);
        mRun     = newRun;
        mPrevSeg = mSeg;
        mPrevAn  = mAn;
        mSeg     = int'(seg_i);
        mAn      = int'(an_i);
    endtask

    task automatic compareVal(string name, int act, int exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        compareVal("value_o", int'(value_o), mValue);
        compareVal("valid_o", int'(valid_o), mValid);
        compareVal("err_o",   int'(err_o),   mErr);
        compareVal("mask_o",  int'(mask_o),  mMask);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        modelEdge();
        checkOutput();
    endtask

    task automatic applyStimulus(int an, int seg, int n);
        an_i  = 4'(an);
        seg_i = 7'(seg);
        repeat (n) step();
    endtask

    task automatic pulseClear();
        clear_i = 1'b1;
        an_i    = 4'h0;
        step();
        clear_i = 1'b0;
    endtask

    initial begin
        segTab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                   7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        resetModel();
        rst_n = 1'b0; seg_i = 7'h00; an_i = 4'h0; clear_i = 1'b0;
        #12;
        compareVal("reset value_o", int'(value_o), 0);
        compareVal("reset mask_o",  int'(mask_o),  0);
        rst_n = 1'b1;

        // Clean frame 1234
        applyStimulus(8, 7'h30, 6);
        compareVal("frame1 mask after d3", int'(mask_o), 4'h8);
        applyStimulus(4, 7'h6D, 6);
        compareVal("frame1 mask after d2", int'(mask_o), 4'hC);
        applyStimulus(2, 7'h79, 6);
        compareVal("frame1 mask after d1", int'(mask_o), 4'hE);
        applyStimulus(1, 7'h33, 6);
        compareVal("frame1 valid", int'(valid_o), 1);
        compareVal("frame1 value", int'(value_o), 16'h1234);
        compareVal("frame1 mask cleared", int'(mask_o), 0);
        step();
        compareVal("frame1 valid one-shot", int'(valid_o), 0);

        // Illegal pattern then recovery, frame 85A0
        applyStimulus(2, 7'h01, 2);
        compareVal("illegal err", int'(err_o), 1);
        compareVal("illegal no commit", int'(mask_o), 0);
        applyStimulus(2, 7'h77, 6);
        compareVal("recover mask", int'(mask_o), 4'h2);
        applyStimulus(8, 7'h7F, 6);
        applyStimulus(4, 7'h5B, 6);
        applyStimulus(1, 7'h7E, 6);
        compareVal("frame2 value", int'(value_o), 16'h85A0);

        // Glitch rejection on digit 0
        pulseClear();
        applyStimulus(1, 7'h7E, 3);
        applyStimulus(1, 7'h30, 1);
        applyStimulus(1, 7'h7E, 4);
        compareVal("glitch not yet committed", int'(mask_o), 0);
        step();
        compareVal("glitch committed", int'(mask_o), 1);

        // Blanking and collisions between digits, frame EDCF
        pulseClear();
        applyStimulus(8, 7'h4F, 6);
        applyStimulus(0, 7'h01, 3);
        applyStimulus(4, 7'h3D, 6);
        applyStimulus(6, 7'h01, 3);
        compareVal("collision no err", int'(err_o), 0);
        applyStimulus(2, 7'h4E, 6);
        applyStimulus(0, 7'h7F, 2);
        applyStimulus(1, 7'h47, 6);
        compareVal("frame3 value", int'(value_o), 16'hEDCF);

        // clear_i mid-frame
        applyStimulus(8, 7'h30, 6);
        applyStimulus(4, 7'h30, 6);
        applyStimulus(2, 7'h30, 6);
        compareVal("clear pre mask", int'(mask_o), 4'hE);
        pulseClear();
        compareVal("clear mask", int'(mask_o), 0);
        compareVal("clear keeps value", int'(value_o), 16'hEDCF);
        applyStimulus(1, 7'h33, 6);
        compareVal("after clear mask", int'(mask_o), 1);
        compareVal("after clear no valid", int'(valid_o), 0);
        applyStimulus(8, 7'h5F, 6);
        applyStimulus(4, 7'h70, 6);
        applyStimulus(2, 7'h7F, 6);
        compareVal("frame4 value", int'(value_o), 16'h6784);

        // Randomized streams
        for (int it = 0; it < 250; it++) begin
            int r, an, seg;
            r = int'($urandom_range(0, 99));
            if (r < 65) begin
                an  = 1 << $urandom_range(0, 3);
                seg = int'(segTab[$urandom_range(0, 15)]);
                applyStimulus(an, seg, int'($urandom_range(1, 7)));
            end else if (r < 78) begin
                an  = ($urandom_range(0, 1) == 0) ? 0 : 3 << $urandom_range(0, 2);
                applyStimulus(an, int'($urandom_range(0, 127)), int'($urandom_range(1, 3)));
            end else if (r < 90) begin
                seg = int'($urandom_range(0, 127));
                while (decode(seg) >= 0) seg = int'($urandom_range(0, 127));
                applyStimulus(1 << $urandom_range(0, 3), seg, int'($urandom_range(1, 2)));
            end else begin
                clear_i = 1'b1;
                step();
                clear_i = 1'b0;
            end
        end

        // Asynchronous reset mid-frame
        pulseClear();
        applyStimulus(1, 7'h30, 6);
        applyStimulus(2, 7'h6D, 6);
        compareVal("pre-reset mask", int'(mask_o), 4'h3);
        an_i = 4'h0; seg_i = 7'h00;
        rst_n = 1'b0;
        #1;
        compareVal("async reset value", int'(value_o), 0);
        compareVal("async reset mask",  int'(mask_o),  0);
        compareVal("async reset valid", int'(valid_o), 0);
        compareVal("async reset err",   int'(err_o),   0);
        resetModel();
        #2;
        rst_n = 1'b1;
        applyStimulus(0, 0, 8);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/lab3_seg_capture_encoder.md
Name: lab3_seg_capture_encoder

Overview:
Receive-side encoder for the seven-segment display path. The block samples a multiplexed 4-digit seven-segment bus (segments A–G plus digit enables) and checks that each segment pattern holds steady. It converts each stable pattern back to its hex nibble and assembles a 16-bit word. It is used to close the loop on the segment decoder and display scanner, so the decoded display contents can be checked in hardware and in simulation.

Parameters:
STABLE_CNT, 4, consecutive identical samples needed to commit a digit (range 2..255)
CNT_W, 8, width of the dwell counter; must satisfy 2^CNT_W > STABLE_CNT

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
seg_i  input  7  segment levels {A,B,C,D,E,F,G}, active-high, A = bit 6
an_i  input  4  digit enables, active-high; an_i[3] = most significant digit
clear_i  input  1  synchronous frame clear
value_o  output  16  last complete frame; digit 3 in [15:12], digit 0 in [3:0]
valid_o  output  1  one-cycle pulse when value_o is updated
err_o  output  1  one-cycle pulse on an illegal pattern under a one-hot enable
mask_o  output  4  digits committed so far in the current frame

Behaviour:
Reset (rst_n low, async):
- value_o = 16'h0000; valid_o = 0; err_o = 0; mask_o = 0.
- Sample registers, dwell counter, previous-sample registers and staged digits all clear to 0.

Sampling:
- seg_i and an_i are synchronous to clk.
- They are registered once into s_seg and s_an at every edge. All logic below operates on s_seg and s_an.

Pattern table (seg -> nibble). Any other pattern is illegal.
- 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7
- 7F->8, 7B->9, 77->A, 1F->b, 4E->C, 3D->d, 4F->E, 47->F

Sample classes:
- Good: s_an is one-hot and s_seg is legal.
- Bad: s_an is one-hot and s_seg is illegal.
- Idle: s_an is not one-hot (zero or multiple bits). This is the blanking interval: no error is raised.

Dwell counter (cnt):
- Good sample equal to the previous good sample (same s_an and same s_seg): cnt <= cnt+1, saturating at STABLE_CNT.
- Good sample that differs from the previous sample: cnt <= 1.
- Bad sample: cnt <= 0, and err_o pulses on the next edge.
- Idle sample: cnt <= 0, no error.

Commit:
- A commit happens on the edge where cnt changes from STABLE_CNT-1 to STABLE_CNT.
- On that edge the decoded nibble is written to staged digit i (i = index of s_an), and mask_o[i] <= 1.
- A commit occurs once per dwell; a held input does not recommit.
- Recommitting an already-set mask bit overwrites the staged nibble.
- Latency: an input held from before edge e commits at edge e+STABLE_CNT.

Frame completion:
- When mask_o == 4'hF, the next edge does all of: value_o <= staged digits, valid_o <= 1 for one cycle, mask_o <= 0.
- If a commit happens on that same edge, its mask bit survives the clear (it starts the next frame).

clear_i:
- Takes effect at the next edge: mask_o <= 0, cnt <= 0, pending completion is cancelled.
- clear_i has priority over commit and over completion.
- value_o holds its current value; err_o is unaffected.

Reset mid-frame: partial digits are discarded and value_o returns to 0.

Test Plan:
- Reset: rst_n low mid-frame with mask_o = 4'b0011 -> all outputs 0 immediately (before the next clk edge); no valid_o after release.
- Clean frame, STABLE_CNT=4: hold an=8/seg=30, then an=4/seg=6D, an=2/seg=79, an=1/seg=33, 6 cycles each -> mask_o steps 8, C, E, F; then a one-cycle valid_o with value_o = 16'h1234.
- Glitch rejection: an=1 with seg=7E for 3 cycles, 1 cycle of 30, then 7E for 4 cycles -> digit 0 commits 0 only after the final 4 cycles; the 30 is never committed.
- Illegal pattern: an=2, seg=7'h01 -> err_o pulses; cnt resets; mask_o[1] stays 0. Then seg=77 held 4 cycles -> nibble A committed.
- Blanking and collisions: an=0 or an=4'b0110 between digits -> no err_o, no commit. Frame 8/4F, 4/3D, 2/4E, 1/47 -> value_o = 16'hEDCF.
- clear_i asserted with mask_o = 4'b1110 -> mask_o = 0 next cycle, value_o unchanged. Completing the frame afterwards needs all four digits again.
